// File: rtl/lsu_pkg.sv
// Shared load/store definitions: RV32 funct3 width codes, controller states,
// and the decode from funct3 to access size and extension.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACC0,
        ACC1,
        FIN
    } lsu_state_e;

    typedef struct packed {
        logic       legal;
        logic [2:0] size;   // bytes: 1, 2 or 4
        logic       sext;
    } lsu_acc_t;

    function automatic lsu_acc_t lsu_decode(input logic [2:0] funct3, input logic is_store);
        lsu_acc_t acc;
        acc = '0;
        case (funct3)
            F3_B:    acc = '{legal: 1'b1, size: 3'd1, sext: 1'b1};
            F3_H:    acc = '{legal: 1'b1, size: 3'd2, sext: 1'b1};
            F3_W:    acc = '{legal: 1'b1, size: 3'd4, sext: 1'b0};
            F3_BU:   acc = '{legal: !is_store, size: 3'd1, sext: 1'b0};
            F3_HU:   acc = '{legal: !is_store, size: 3'd2, sext: 1'b0};
            default: acc = '0;
        endcase
        return acc;
    endfunction

    function automatic logic [7:0] lsu_size_mask(input logic [2:0] size);
        return (8'd1 << size) - 8'd1;
    endfunction

endpackage

// File: rtl/lsu_if.sv
// Core-side request/response and memory-side access signals of the LSU.
// slave is the controller's view; master is the core plus memory view.
interface lsu_if #(
    parameter int ADDR_WIDTH = 32
) ();

    logic                  start;
    logic                  is_store;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] addr;
    logic [31:0]           wdata;
    logic                  busy;
    logic                  done;
    logic [31:0]           rdata;
    logic                  err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ready;
    logic [31:0]           mem_rdata;

    modport slave (
        input  start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        output busy, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

    modport master (
        output start, is_store, funct3, addr, wdata, mem_ready, mem_rdata,
        input  busy, done, rdata, err, mem_req, mem_we, mem_addr, mem_be, mem_wdata
    );

endinterface

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables and write data for each word access, and
// the merge/extension of one or two read words into the load result.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic [2:0]  size,
    input  logic        sext,
    input  logic        second,
    input  logic [31:0] wdata,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic        split,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] load_data
);

    logic [7:0]  mask;
    logic [2:0]  rsh;
    logic [31:0] merged;

    always_comb begin
        mask  = lsu_size_mask(size);
        split = (4'(offset) + 4'(size)) > 4'd4;
        rsh   = 3'd4 - 3'(offset);
        // The second word carries the bytes that spilled past the word boundary.
        if (second) begin
            be         = 4'(mask >> rsh);
            lane_wdata = wdata >> {rsh, 3'b000};
        end else begin
            be         = 4'(mask << offset);
            lane_wdata = wdata << {offset, 3'b000};
        end
        merged = 32'({word1, word0} >> {offset, 3'b000});
        case (size)
            3'd1:    load_data = {{24{sext & merged[7]}}, merged[7:0]};
            3'd2:    load_data = {{16{sext & merged[15]}}, merged[15:0]};
            default: load_data = merged;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store controller: accepts one core request at a time and turns it into
// one or two word-aligned memory accesses, splitting across word boundaries.
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32   // only 32 is supported
) (
    input  logic clk,
    input  logic reset,
    lsu_if.slave bus
);

    lsu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] word0_q, word0_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  is_store_q, is_store_d;
    logic                  sext_q, sext_d;
    logic [2:0]            size_q, size_d;
    logic                  err_q, err_d;

    lsu_acc_t              acc;
    logic                  split;
    logic                  second;
    logic                  mem_active;
    logic [3:0]            lane_be;
    logic [31:0]           lane_wdata;
    logic [31:0]           load_data;
    logic [31:0]           merge_word0;
    logic [ADDR_WIDTH-1:0] word_addr;

    assign second      = (state_q == ACC1);
    assign mem_active  = (state_q == ACC0) || (state_q == ACC1);
    // A non-split load completes in ACC0, so its word comes straight off the bus.
    assign merge_word0 = second ? word0_q : bus.mem_rdata;
    assign word_addr   = {addr_q[ADDR_WIDTH-1:2], 2'b00};

    lsu_align u_align (
        .offset     (addr_q[1:0]),
        .size       (size_q),
        .sext       (sext_q),
        .second     (second),
        .wdata      (wdata_q),
        .word0      (merge_word0),
        .word1      (bus.mem_rdata),
        .split      (split),
        .be         (lane_be),
        .lane_wdata (lane_wdata),
        .load_data  (load_data)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        word0_d    = word0_q;
        rdata_d    = rdata_q;
        is_store_d = is_store_q;
        sext_d     = sext_q;
        size_d     = size_q;
        err_d      = err_q;
        acc        = lsu_decode(bus.funct3, bus.is_store);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    addr_d     = bus.addr;
                    wdata_d    = bus.wdata;
                    is_store_d = bus.is_store;
                    size_d     = acc.size;
                    sext_d     = acc.sext;
                    if (acc.legal) begin
                        state_d = ACC0;
                    end else begin
                        state_d = FIN;
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end
                end
            end
            ACC0: begin
                if (bus.mem_ready) begin
                    word0_d = bus.mem_rdata;
                    if (split) begin
                        state_d = ACC1;
                    end else begin
                        state_d = FIN;
                        err_d   = 1'b0;
                        rdata_d = is_store_q ? '0 : load_data;
                    end
                end
            end
            ACC1: begin
                if (bus.mem_ready) begin
                    state_d = FIN;
                    err_d   = 1'b0;
                    rdata_d = is_store_q ? '0 : load_data;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request payload is only observed while an access is active, so it needs no reset.
    always_ff @(posedge clk) begin
        addr_q     <= addr_d;
        wdata_q    <= wdata_d;
        word0_q    <= word0_d;
        is_store_q <= is_store_d;
        sext_q     <= sext_d;
        size_q     <= size_d;
    end

    always_comb begin
        bus.busy      = (state_q != IDLE);
        bus.done      = (state_q == FIN);
        bus.rdata     = rdata_q;
        bus.err       = err_q;
        bus.mem_req   = mem_active;
        bus.mem_we    = mem_active & is_store_q;
        bus.mem_addr  = '0;
        bus.mem_be    = '0;
        bus.mem_wdata = '0;
        if (mem_active) begin
            bus.mem_addr  = second ? word_addr + ADDR_WIDTH'(4) : word_addr;
            bus.mem_be    = lane_be;
            bus.mem_wdata = lane_wdata;
        end
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 32, meaning byte-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 32, meaning memory word width; only 32 is supported.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have these core-side ports:
- start, input, 1: request strobe.
- is_store, input, 1: 1 = store, 0 = load.
- funct3, input, 3: RV32 load/store width code.
- addr, input, ADDR_WIDTH: byte address.
- wdata, input, 32: store data, right-aligned.
REQ-006 The block SHALL have these core-side outputs:
- busy, output, 1: a request is in progress.
- done, output, 1: one-cycle completion pulse.
- rdata, output, 32: extended load result.
- err, output, 1: illegal funct3, valid with done.
REQ-007 The block SHALL have these memory-side ports:
- mem_req, output, 1: memory access request.
- mem_we, output, 1: write enable.
- mem_addr, output, ADDR_WIDTH: word-aligned address; bits [1:0] always 0.
- mem_be, output, 4: byte enables.
- mem_wdata, output, 32: lane-positioned write data.
- mem_ready, input, 1: access completes this cycle.
- mem_rdata, input, 32: read word, valid when mem_req and mem_ready are both high.

Function
REQ-008 Size S and extension SHALL follow funct3:
- 000: 1 byte, signed.
- 001: 2 bytes, signed.
- 010: 4 bytes.
- 100: 1 byte, unsigned; load only.
- 101: 2 bytes, unsigned; load only.
- Any other code, or 100/101 with is_store=1, is illegal.
REQ-009 The FSM SHALL have states IDLE, ACC0, ACC1 and FIN; busy = (state != IDLE).
REQ-010 start SHALL be sampled only in IDLE; start while busy is ignored.
- Legal request: go to ACC0.
- Illegal request: go to FIN with err=1 and no memory access.
- Inputs are latched at acceptance.
REQ-011 With offset o = addr[1:0], a request SHALL be split when o+S > 4.
REQ-012 ACC0 SHALL drive the first access:
- mem_req=1, mem_we=is_store.
- mem_addr = {addr[ADDR_WIDTH-1:2],2'b00}.
- mem_be = (((1<<S)-1)<<o) truncated to 4 bits.
- mem_wdata = wdata<<(8*o).
REQ-013 ACC1 SHALL drive the second access:
- mem_addr = first word address + 4, wrapping modulo 2^ADDR_WIDTH.
- mem_be = ((1<<S)-1)>>(4-o).
- mem_wdata = wdata>>(8*(4-o)).
REQ-014 All memory-side outputs SHALL be held stable while mem_req=1 and mem_ready=0; there is no timeout.
REQ-015 On mem_req and mem_ready both high in ACC0, the FSM SHALL capture mem_rdata as word0, then go to ACC1 if split, else FIN.
REQ-016 On mem_req and mem_ready both high in ACC1, the FSM SHALL capture word1 and go to FIN.
REQ-017 In FIN, done SHALL be 1 for exactly one cycle, then the FSM returns to IDLE.
- Loads: rdata = S bytes of ({word1,word0} >> 8*o), sign- or zero-extended.
- Stores: rdata = 0.
REQ-018 rdata and err SHALL hold their values until the next done.
REQ-019 In IDLE and FIN, mem_req, mem_we and mem_be SHALL be 0.
REQ-020 Latency from start edge to done SHALL be:
- Aligned request, mem_ready constantly 1: 2 cycles.
- Split request: 3 cycles.
- Illegal request: 1 cycle.
- Each stall cycle adds 1.

Reset
REQ-021 While reset=1, the FSM SHALL be in IDLE and every output SHALL be 0, asserted immediately without waiting for clk.
REQ-022 Reset asserted during ACC0 or ACC1 SHALL abort the access; mem_req drops asynchronously and no done is issued.

Structure
REQ-023 Package lsu_pkg SHALL hold the funct3 constants, the state enum and the size/extension decode function.
REQ-024 Combinational lane logic (be/wdata shift, load merge/extend) SHALL live in sub-module lsu_align; lsu_ctrl holds the FSM and registers.

Verification
REQ-025 Aligned sw: addr=0x10, wdata=0xDEADBEEF, mem_ready=1.
- One access: mem_addr=0x10, mem_be=1111, mem_wdata=0xDEADBEEF, mem_we=1.
- done 2 cycles after start.
REQ-026 lb at 0x13 with mem[0x10]=0x80000000 -> be=1000, rdata=0xFFFFFF80.
REQ-027 Split sw: addr=0x0E, wdata=0x11223344.
- Access 0: mem_addr=0x0C, be=1100, mem_wdata=0x33440000.
- Access 1: mem_addr=0x10, be=0011, mem_wdata=0x00001122.
- done at start+3.
REQ-028 lhu at 0x0F with mem[0x0C]=0xAB000000 and mem[0x10]=0x000000CD.
- rdata=0x0000CDAB.
- Repeat with mem_ready low for 3 cycles in ACC1: outputs stable, done delayed 3 cycles.
REQ-029 Edge cases:
- funct3=011 -> done at start+1, err=1, no mem_req.
- lw at 0xFFFFFFFE -> second mem_addr=0x00000000.
- reset pulse in ACC1 -> all outputs 0, no done, next request completes normally.
